// File: rtl/ann_pipe_reg.sv
// Handshaked two-entry skid pipeline register for the ANN datapath, with registered
// in_ready/out_valid and a wrapping count of delivered vectors. Optional flush: ANN_PIPE_FLUSH_EN.
module ann_pipe_reg #(
    parameter int W     = 10,
    parameter int N_CH  = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data [N_CH-1:0],
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data [N_CH-1:0],
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] xfer_cnt
`ifdef ANN_PIPE_FLUSH_EN
    ,
    input  logic             flush
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t             state_r;
    state_t             next_state_s;
    logic               in_ready_r;
    logic               out_valid_r;
    logic [W-1:0]       main_r [N_CH-1:0];
    logic [W-1:0]       skid_r [N_CH-1:0];
    logic [CNT_W-1:0]   cnt_r;
    logic               in_hs_s;
    logic               out_hs_s;
    logic               flush_s;
    logic               ld_main_in_s;
    logic               ld_main_skid_s;
    logic               ld_skid_s;

`ifdef ANN_PIPE_FLUSH_EN
    assign flush_s = flush;
`else
    assign flush_s = 1'b0;
`endif

    assign in_hs_s  = in_valid & in_ready_r;
    assign out_hs_s = out_valid_r & out_ready;

    // Next-state and data-load selection; a flush empties the stage and suppresses all loads.
    always_comb begin
        next_state_s   = state_r;
        ld_main_in_s   = 1'b0;
        ld_main_skid_s = 1'b0;
        ld_skid_s      = 1'b0;
        if (flush_s) begin
            next_state_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (in_hs_s) begin
                        next_state_s = ST_ONE;
                        ld_main_in_s = 1'b1;
                    end else begin
                        next_state_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (in_hs_s && out_hs_s) begin
                        next_state_s = ST_ONE;
                        ld_main_in_s = 1'b1;
                    end else if (in_hs_s) begin
                        next_state_s = ST_FULL;
                        ld_skid_s    = 1'b1;
                    end else if (out_hs_s) begin
                        next_state_s = ST_EMPTY;
                    end else begin
                        next_state_s = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (out_hs_s) begin
                        next_state_s   = ST_ONE;
                        ld_main_skid_s = 1'b1;
                    end else begin
                        next_state_s = ST_FULL;
                    end
                end
                default: begin
                    next_state_s = ST_EMPTY;
                end
            endcase
        end
    end

    // State register with registered ready/valid derived from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_EMPTY;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            in_ready_r  <= (next_state_s != ST_FULL);
            out_valid_r <= (next_state_s != ST_EMPTY);
        end
    end

    // Main and skid data registers; main keeps its value when the stage drains.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_CH; i++) begin
                main_r[i] <= {W{1'b0}};
                skid_r[i] <= {W{1'b0}};
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (ld_main_in_s) begin
                    main_r[i] <= in_data[i];
                end else if (ld_main_skid_s) begin
                    main_r[i] <= skid_r[i];
                end else begin
                    main_r[i] <= main_r[i];
                end
                if (ld_skid_s) begin
                    skid_r[i] <= in_data[i];
                end else begin
                    skid_r[i] <= skid_r[i];
                end
            end
        end
    end

    // Delivered-vector counter, wrapping; output handshakes count even during a flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (out_hs_s) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = main_r;
    assign occupancy = state_r;
    assign xfer_cnt  = cnt_r;

endmodule

// File: tb/tb_ann_pipe_reg.sv
// Self-checking bench for ann_pipe_reg: directed plus randomized stimulus against a
// queue-based reference model; a second instance with CNT_W=4 exercises counter wrap.
module tb_ann_pipe_reg;

    localparam int W = 10;
    localparam int N = 3;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         out_ready;
    logic [W-1:0] in_data [N-1:0];
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data [N-1:0];
    logic [1:0]   occupancy;
    logic [15:0]  xfer_cnt;
    logic         sm_in_ready;
    logic         sm_out_valid;
    logic [W-1:0] sm_out_data [N-1:0];
    logic [1:0]   sm_occupancy;
    logic [3:0]   sm_xfer_cnt;
`ifdef ANN_PIPE_FLUSH_EN
    logic         flush;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [3*W-1:0] q[$];
    logic [3*W-1:0] out_exp;
    logic           ir_exp;
    int unsigned    cnt_exp;

    ann_pipe_reg #(.W(W), .N_CH(N), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy), .xfer_cnt(xfer_cnt)
`ifdef ANN_PIPE_FLUSH_EN
        , .flush(flush)
`endif
    );

    ann_pipe_reg #(.W(W), .N_CH(N), .CNT_W(4)) u_small (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(sm_in_ready), .in_data(in_data),
        .out_valid(sm_out_valid), .out_ready(out_ready), .out_data(sm_out_data),
        .occupancy(sm_occupancy), .xfer_cnt(sm_xfer_cnt)
`ifdef ANN_PIPE_FLUSH_EN
        , .flush(flush)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3*W-1:0] pack_out();
        return {out_data[2], out_data[1], out_data[0]};
    endfunction

    function automatic logic [3*W-1:0] pack_sm();
        return {sm_out_data[2], sm_out_data[1], sm_out_data[0]};
    endfunction

    task automatic set_in(input int a, input int b, input int c);
        in_data[0] = a[W-1:0];
        in_data[1] = b[W-1:0];
        in_data[2] = c[W-1:0];
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, q.size() > 0});
        chk({tag, ".occupancy"}, {30'd0, occupancy}, q.size());
        chk({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, ir_exp});
        chk({tag, ".out_data"},  {2'd0, pack_out()}, {2'd0, out_exp});
        chk({tag, ".xfer_cnt"},  {16'd0, xfer_cnt},  cnt_exp % 32'd65536);
        chk({tag, ".sm_cnt"},    {28'd0, sm_xfer_cnt}, cnt_exp % 32'd16);
        chk({tag, ".sm_vec"},    {sm_in_ready, sm_out_valid, sm_occupancy, pack_sm()},
                                 {ir_exp, q.size() > 0, q.size() == 2, q.size() == 1, out_exp});
    endtask

    task automatic model_reset();
        q.delete();
        out_exp = '0;
        ir_exp  = 1'b0;
        cnt_exp = 0;
    endtask

    // One clock: decide handshakes from pre-edge state, advance the model, check at edge+1.
    task automatic cycle(input string tag);
        bit ih, oh, fl;
        logic [3*W-1:0] v;
        ih = in_valid && ir_exp;
        oh = (q.size() > 0) && out_ready;
        v  = {in_data[2], in_data[1], in_data[0]};
        fl = 1'b0;
`ifdef ANN_PIPE_FLUSH_EN
        fl = flush;
`endif
        @(posedge clk);
        if (oh) begin
            void'(q.pop_front());
            cnt_exp++;
        end
        if (fl) q.delete();
        else if (ih) q.push_back(v);
        if (q.size() > 0) out_exp = q[0];
        ir_exp = (q.size() < 2);
        #1;
        check_all(tag);
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        set_in(0, 0, 0);
`ifdef ANN_PIPE_FLUSH_EN
        flush = 1'b0;
`endif
        model_reset();
        #3;
        check_all("in_reset");
        @(posedge clk);
        #1;
        check_all("in_reset2");
        reset = 1'b1;
        cycle("idle1");
        chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

        // Streaming with out_ready high
        out_ready = 1'b1;
        in_valid  = 1'b1;
        set_in(1, 2, 3); cycle("stream1");
        chk("stream1_data", {2'd0, pack_out()}, {2'd0, 10'd3, 10'd2, 10'd1});
        set_in(4, 5, 6); cycle("stream2");
        set_in(7, 8, 9); cycle("stream3");
        in_valid = 1'b0;
        cycle("stream4");
        chk("stream_cnt", {16'd0, xfer_cnt}, 32'd3);

        // Back-pressure
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_in(10, 20, 30); cycle("bp1");
        set_in(40, 50, 60); cycle("bp2");
        chk("bp_full_occ", {30'd0, occupancy}, 32'd2);
        set_in(70, 80, 90); cycle("bp3");
        cycle("bp4");
        out_ready = 1'b1;
        cycle("bp5");
        cycle("bp6");
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) cycle("bp_drain");
        chk("bp_cnt", {16'd0, xfer_cnt}, 32'd6);

        // Randomized traffic, upstream holds a stalled vector
        for (int i = 0; i < 300; i++) begin
            if (!(in_valid && !ir_exp)) begin
                in_valid = ($urandom_range(0, 3) != 0);
                set_in($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023));
            end
            out_ready = ($urandom_range(0, 2) != 0);
            cycle("rand");
        end

        // Async reset while FULL
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_in(11, 12, 13); cycle("ar1");
        set_in(14, 15, 16); cycle("ar2");
        set_in(17, 18, 19); cycle("ar3");
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        chk("async_rst_data", {2'd0, pack_out()}, 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        cycle("post_rst_idle");

        // 17 back-to-back transfers: small counter wraps to 1
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 17; i++) begin
            set_in(100 + i, 200 + i, 300 + i);
            cycle("wrap");
            if (i == 0) chk("first_after_rst", {2'd0, pack_out()}, {2'd0, 10'd300, 10'd200, 10'd100});
        end
        in_valid = 1'b0;
        cycle("wrap_end");
        chk("wrap_small_cnt", {28'd0, sm_xfer_cnt}, 32'd1);
        chk("wrap_big_cnt", {16'd0, xfer_cnt}, 32'd17);

`ifdef ANN_PIPE_FLUSH_EN
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_in(21, 22, 23); cycle("fl1");
        set_in(24, 25, 26); cycle("fl2");
        set_in(5, 5, 5);
        flush = 1'b1;
        cycle("flush");
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_occ", {30'd0, occupancy}, 32'd0);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle("post_flush");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ann_pipe_reg.md
# ann_pipe_reg

Parametrised, handshaked pipeline register for the drowsiness-detector ANN datapath. It carries a vector of N_CH neuron/feature values, each W bits, between ANN layer stages. A two-entry skid buffer provides full throughput with a fully registered `in_ready`, so no combinational ready path crosses stages. It also keeps a wrapping count of delivered vectors for layer-level bookkeeping.

## Interface
Parameters:
- `W`, 10, bit width of one channel value
- `N_CH`, 3, number of channels per vector (≥1)
- `CNT_W`, 16, width of the transfer counter

Ports:
- `clk`  input  1  rising-edge clock
- `reset`  input  1  asynchronous, active-low reset
- `in_valid`  input  1  upstream vector valid
- `in_ready`  output  1  block can accept a vector (registered)
- `in_data`  input  W × N_CH (unpacked array [N_CH-1:0])  upstream vector
- `out_valid`  output  1  output vector valid (registered)
- `out_ready`  input  1  downstream accepts
- `out_data`  output  W × N_CH (unpacked array [N_CH-1:0])  output vector (registered)
- `occupancy`  output  2  number of held vectors, 0..2
- `xfer_cnt`  output  CNT_W  count of completed output handshakes
- `flush`  input  1  synchronous flush (only with `ANN_PIPE_FLUSH_EN`)

## Operation
- Input handshake: `in_valid & in_ready`. Output handshake: `out_valid & out_ready`.
- Storage: main register (drives `out_data`) and skid register.
- States (`occupancy`): EMPTY(0), ONE(1), FULL(2).
- EMPTY: input hs → main ← `in_data`, go to ONE.
- ONE, input and output hs together → main ← `in_data`, stay ONE. Input hs only → skid ← `in_data`, go to FULL. Output hs only → go to EMPTY.
- FULL: `in_ready`=0, so no input hs. Output hs → main ← skid, go to ONE.
- `out_valid` = (state ≠ EMPTY), registered with state.
- `in_ready` is a flop whose next value is (next state ≠ FULL).
- Order is strictly preserved. No vector is dropped or duplicated.
- `in_valid` while `in_ready`=0 has no effect. Upstream must hold data until hs.
- Draining to EMPTY leaves `out_data` at its last value. Only reset zeroes it.
- `xfer_cnt` increments by 1 on each output hs and wraps modulo 2^CNT_W.
- Channel values pass bit-exact. No arithmetic is applied to data.

## Timing
- Reset (`reset`=0, asynchronous) sets: state EMPTY, `occupancy`=0, `out_valid`=0, `in_ready`=0, `out_data` all channels 0, skid 0, `xfer_cnt`=0.
- `in_ready` rises on the first `clk` edge after `reset` deasserts.
- Latency is 1 cycle: a vector accepted at edge k appears on `out_data` with `out_valid`=1 after edge k.
- Throughput is one vector per cycle while `out_ready`=1.
- Back-pressure: once `out_ready` drops, at most one more vector is accepted (into skid). `in_ready` falls one edge later.
- When FULL, an output hs and main←skid occur at edge k. `in_ready`=1 after edge k.
- Reset asserted mid-transfer discards all held vectors immediately, with no hs completing.

## Configuration
- `ANN_PIPE_FLUSH_EN` defined: the `flush` port exists.
  - `flush`=1 at an edge forces state EMPTY, `occupancy`=0, `out_valid`=0, and `in_ready`=1 after that edge.
  - Any vector presented with an input hs in that same cycle is discarded.
  - An output hs in that same cycle still completes and still increments `xfer_cnt`.
  - Data registers and `xfer_cnt` are otherwise unchanged.
- Not defined: no `flush` port. Behaviour is as above with no flush path.

## Test plan
- Reset then idle: during reset, all outputs are 0. One edge after release, `in_ready`=1, `out_valid`=0, `occupancy`=0.
- Streaming with `out_ready`=1: send {1,2,3},{4,5,6},{7,8,9} on consecutive cycles → same vectors out on consecutive cycles, each 1 cycle later, and `xfer_cnt`=3.
- Back-pressure with `out_ready`=0: send {10,20,30} then {40,50,60} → `occupancy`=2 and `in_ready`=0. A third vector {70,80,90} held on input is not accepted. Raise `out_ready` → outputs arrive in order {10,20,30},{40,50,60},{70,80,90}.
- Counter wrap with `CNT_W`=4: 17 output handshakes → `xfer_cnt`=1.
- Async reset while FULL with `out_ready`=0: assert `reset` between edges → `out_valid`, `occupancy` and `out_data` go to 0 immediately. After release, the first new vector is delivered unchanged.
- (`ANN_PIPE_FLUSH_EN`) With `occupancy`=2, assert `flush` together with `in_valid`=1 and data {5,5,5} → after the edge, `out_valid`=0 and `occupancy`=0. {5,5,5} is never output.
